// File: rtl/tiq_adc_pkg.sv
// Shared constants and width helpers for the TIQ ADC digital back-end.
package tiq_adc_pkg;

    localparam int TIQ_N_LEVELS    = 7;
    localparam int TIQ_SYNC_STAGES = 2;
    localparam int TIQ_AVG_LOG2    = 2;

    // Ceiling log2, usable in constant expressions.
    function automatic int tiq_clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Bits needed for a binary level 0..n_levels.
    function automatic int tiq_code_w(input int n_levels);
        return tiq_clog2(n_levels + 1);
    endfunction

endpackage

// File: rtl/tiq_bubble_fix.sv
// Combinational bubble correction: 3-input majority over the thermometer code,
// then one-hot of the highest 1->0 transition, plus a raw non-monotonic flag.
module tiq_bubble_fix
    import tiq_adc_pkg::*;
#(
    parameter int N_LEVELS = TIQ_N_LEVELS
) (
    input  logic [N_LEVELS-1:0] therm,
    output logic [N_LEVELS:0]   onehot,
    output logic                bubble_err
);

    logic [N_LEVELS+1:0] s_ext;
    logic [N_LEVELS-1:0] fixed;
    logic [N_LEVELS+1:0] t_ext;
    logic [N_LEVELS:0]   edges;
    logic                found;

    // Majority filter, transition detect, and highest-edge priority pick.
    always_comb begin
        s_ext      = {1'b0, therm, 1'b1};
        fixed      = '0;
        t_ext      = '0;
        edges      = '0;
        onehot     = '0;
        found      = 1'b0;
        bubble_err = 1'b0;

        for (int i = 0; i < N_LEVELS; i++) begin
            fixed[i] = (s_ext[i] & s_ext[i+1]) | (s_ext[i] & s_ext[i+2]) |
                       (s_ext[i+1] & s_ext[i+2]);
        end

        t_ext = {1'b0, fixed, 1'b1};
        for (int i = 0; i <= N_LEVELS; i++) begin
            edges[i] = t_ext[i] & ~t_ext[i+1];
        end

        // A double bubble survives the majority filter as several edges;
        // the highest one wins.
        for (int i = N_LEVELS; i >= 0; i--) begin
            if (edges[i] && !found) begin
                onehot[i] = 1'b1;
                found     = 1'b1;
            end
        end

        bubble_err = |(~therm[N_LEVELS-2:0] & therm[N_LEVELS-1:1]);
    end

endmodule

// File: rtl/tiq_therm_decoder.sv
// TIQ ADC back-end: synchroniser, bubble-fix stage, binary encoder and a
// 2^AVG_LOG2-sample decimating accumulator with valid strobes.
module tiq_therm_decoder
    import tiq_adc_pkg::*;
#(
    parameter int N_LEVELS    = TIQ_N_LEVELS,
    parameter int SYNC_STAGES = TIQ_SYNC_STAGES,
    parameter int AVG_LOG2    = TIQ_AVG_LOG2,
    localparam int CODE_W     = tiq_code_w(N_LEVELS),
    localparam int SUM_W      = CODE_W + AVG_LOG2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                acc_clr,
    input  logic [N_LEVELS-1:0] therm_in,
    output logic [N_LEVELS:0]   onehot_out,
    output logic                bubble_err,
    output logic [CODE_W-1:0]   code_out,
    output logic                code_valid,
    output logic [SUM_W-1:0]    sum_out,
    output logic                sum_valid
);

    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);

    logic [SYNC_STAGES-1:0][N_LEVELS-1:0] sync_q;
    logic [SYNC_STAGES-1:0]               en_q;
    logic [N_LEVELS:0]                    onehot_fix;
    logic                                 bubble_fix;
    logic                                 valid_s1;
    logic [CODE_W-1:0]                    code_enc;
    logic [SUM_W-1:0]                     code_ext;
    logic [SUM_W-1:0]                     acc;
    logic [CNT_W-1:0]                     cnt;

    // Synchroniser chain for the asynchronous comparator bits, with en riding alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            en_q   <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], therm_in};
            en_q   <= {en_q[SYNC_STAGES-2:0], en};
        end
    end

    tiq_bubble_fix #(
        .N_LEVELS (N_LEVELS)
    ) u_bubble_fix (
        .therm      (sync_q[SYNC_STAGES-1]),
        .onehot     (onehot_fix),
        .bubble_err (bubble_fix)
    );

    // Stage 1: register the corrected one-hot level and the bubble flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_out <= (N_LEVELS + 1)'(1);
            bubble_err <= 1'b0;
            valid_s1   <= 1'b0;
        end else begin
            onehot_out <= onehot_fix;
            bubble_err <= bubble_fix;
            valid_s1   <= en_q[SYNC_STAGES-1];
        end
    end

    // One-hot to binary index.
    always_comb begin
        code_enc = '0;
        for (int i = 0; i <= N_LEVELS; i++) begin
            if (onehot_out[i]) begin
                code_enc = CODE_W'(i);
            end
        end
    end

    // Stage 2: register the binary code and its qualifier.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_out   <= '0;
            code_valid <= 1'b0;
        end else begin
            code_out   <= code_enc;
            code_valid <= valid_s1;
        end
    end

    assign code_ext = SUM_W'(code_out);

    // Decimator: sum each window of valid codes; acc_clr discards a partial window.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            sum_out   <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (acc_clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (code_valid) begin
                if (cnt == CNT_MAX) begin
                    sum_out   <= acc + code_ext;
                    sum_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc + code_ext;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tiq_therm_decoder.sv
// Bench for tiq_therm_decoder at N_LEVELS=7, SYNC_STAGES=2, AVG_LOG2=2.
module tb_tiq_therm_decoder;

    localparam int WIN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       acc_clr;
    logic [6:0] therm_in;
    logic [7:0] onehot_out;
    logic       bubble_err;
    logic [2:0] code_out;
    logic       code_valid;
    logic [4:0] sum_out;
    logic       sum_valid;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [6:0] m_tq[$];
    bit         m_eq[$];
    int         m_acc;
    int         m_n;
    logic [7:0] exp_onehot;
    logic       exp_bubble;
    logic [2:0] exp_code;
    logic       exp_cv;
    logic [4:0] exp_sum;
    logic       exp_sv;

    tiq_therm_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .acc_clr    (acc_clr),
        .therm_in   (therm_in),
        .onehot_out (onehot_out),
        .bubble_err (bubble_err),
        .code_out   (code_out),
        .code_valid (code_valid),
        .sum_out    (sum_out),
        .sum_valid  (sum_valid)
    );

    always #5 clk = ~clk;

    // Level after majority correction: highest 1->0 step of the corrected code.
    function automatic int ref_level(input logic [6:0] t);
        int s[9];
        int g[9];
        int lvl;
        s[0] = 1;
        s[8] = 0;
        for (int i = 0; i < 7; i++) s[i+1] = int'(t[i]);
        g[0] = 1;
        g[8] = 0;
        for (int i = 0; i < 7; i++) g[i+1] = ((s[i] + s[i+1] + s[i+2]) >= 2) ? 1 : 0;
        lvl = 0;
        for (int i = 0; i < 8; i++) if (g[i] == 1 && g[i+1] == 0) lvl = i;
        return lvl;
    endfunction

    function automatic logic ref_bubble(input logic [6:0] t);
        for (int i = 0; i < 6; i++) if (t[i] == 1'b0 && t[i+1] == 1'b1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] therm_of(input int lvl);
        return 7'((1 << lvl) - 1);
    endfunction

    task automatic model_reset();
        m_tq       = '{7'd0, 7'd0, 7'd0, 7'd0};
        m_eq       = '{1'b0, 1'b0, 1'b0, 1'b0};
        m_acc      = 0;
        m_n        = 0;
        exp_onehot = 8'h01;
        exp_bubble = 1'b0;
        exp_code   = 3'd0;
        exp_cv     = 1'b0;
        exp_sum    = 5'd0;
        exp_sv     = 1'b0;
    endtask

    // One clock: drive inputs, advance the model at the edge, return at the next negedge.
    task automatic apply(input logic e, input logic [6:0] t, input logic clr);
        en       = e;
        therm_in = t;
        acc_clr  = clr;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            exp_sv = 1'b0;
            if (clr) begin
                m_acc = 0;
                m_n   = 0;
            end else if (exp_cv) begin
                if (m_n == WIN - 1) begin
                    exp_sum = 5'(m_acc + int'(exp_code));
                    exp_sv  = 1'b1;
                    m_acc   = 0;
                    m_n     = 0;
                end else begin
                    m_acc = m_acc + int'(exp_code);
                    m_n   = m_n + 1;
                end
            end
            m_tq.push_back(t);
            void'(m_tq.pop_front());
            m_eq.push_back(e);
            void'(m_eq.pop_front());
            exp_onehot = 8'b1 << ref_level(m_tq[1]);
            exp_bubble = ref_bubble(m_tq[1]);
            exp_code   = 3'(ref_level(m_tq[0]));
            exp_cv     = m_eq[0];
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        apply(1'b0, 7'd0, 1'b0);
        apply(1'b0, 7'd0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic wait_sum(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            apply(1'b0, 7'd0, 1'b0);
            if (sum_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (onehot_out !== 8'h01) begin n_err++; $display("FAIL reset_onehot: got %h want 01", onehot_out); end
        n_vec++; if (bubble_err !== 1'b0) begin n_err++; $display("FAIL reset_bubble: got %b want 0", bubble_err); end
        n_vec++; if (code_out !== 3'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", code_out); end
        n_vec++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL reset_code_valid: got %b want 0", code_valid); end
        n_vec++; if (sum_out !== 5'd0) begin n_err++; $display("FAIL reset_sum: got %0d want 0", sum_out); end
        n_vec++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL reset_sum_valid: got %b want 0", sum_valid); end
    endtask

    task automatic test_static();
        do_reset();
        apply(1'b1, 7'b0011111, 1'b0);
        apply(1'b1, 7'b0011111, 1'b0);
        n_vec++; if (onehot_out !== 8'h01) begin n_err++; $display("FAIL static_onehot_early: got %h want 01", onehot_out); end
        apply(1'b1, 7'b0011111, 1'b0);
        n_vec++; if (onehot_out !== 8'b0010_0000) begin n_err++; $display("FAIL static_onehot: got %b want 00100000", onehot_out); end
        n_vec++; if (bubble_err !== 1'b0) begin n_err++; $display("FAIL static_bubble: got %b want 0", bubble_err); end
        n_vec++; if (code_valid !== 1'b0) begin n_err++; $display("FAIL static_valid_early: got %b want 0", code_valid); end
        apply(1'b0, 7'b0011111, 1'b0);
        n_vec++; if (code_out !== 3'd5) begin n_err++; $display("FAIL static_code: got %0d want 5", code_out); end
        n_vec++; if (code_valid !== 1'b1) begin n_err++; $display("FAIL static_code_valid: got %b want 1", code_valid); end
    endtask

    task automatic test_bubble();
        logic [6:0] pats [3] = '{7'b0010111, 7'b0101111, 7'b1010101};
        int         want [3] = '{4, 5, 6};
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 4; i++) apply(1'b1, pats[p], 1'b0);
            n_vec++; if (bubble_err !== 1'b1) begin n_err++; $display("FAIL bubble_flag[%0d]: got %b want 1", p, bubble_err); end
            n_vec++; if (code_out !== 3'(want[p])) begin n_err++; $display("FAIL bubble_code[%0d]: got %0d want %0d", p, code_out, want[p]); end
            n_vec++; if (onehot_out !== exp_onehot) begin n_err++; $display("FAIL bubble_onehot[%0d]: got %b want %b", p, onehot_out, exp_onehot); end
        end
    endtask

    task automatic test_extremes();
        bit got;
        do_reset();
        for (int i = 0; i < 4; i++) apply(1'b0, 7'b0000000, 1'b0);
        n_vec++; if (onehot_out !== 8'h01) begin n_err++; $display("FAIL zero_onehot: got %h want 01", onehot_out); end
        n_vec++; if (code_out !== 3'd0) begin n_err++; $display("FAIL zero_code: got %0d want 0", code_out); end
        for (int i = 0; i < 4; i++) apply(1'b1, 7'b1111111, 1'b0);
        n_vec++; if (onehot_out !== 8'h80) begin n_err++; $display("FAIL full_onehot: got %h want 80", onehot_out); end
        n_vec++; if (code_out !== 3'd7) begin n_err++; $display("FAIL full_code: got %0d want 7", code_out); end
        wait_sum(12, got);
        n_vec++; if (!got) begin n_err++; $display("FAIL full_sum_timeout: got no strobe want one"); end
        n_vec++; if (sum_out !== 5'd28) begin n_err++; $display("FAIL full_sum: got %0d want 28", sum_out); end
    endtask

    task automatic test_decimation();
        bit got;
        do_reset();
        for (int k = 1; k <= 4; k++) apply(1'b1, therm_of(k), 1'b0);
        wait_sum(12, got);
        n_vec++; if (!got) begin n_err++; $display("FAIL dec_timeout: got no strobe want one"); end
        n_vec++; if (sum_out !== 5'd10) begin n_err++; $display("FAIL dec_sum: got %0d want 10", sum_out); end
        apply(1'b0, 7'd0, 1'b0);
        n_vec++; if (sum_valid !== 1'b0) begin n_err++; $display("FAIL dec_strobe_width: got %b want 0", sum_valid); end
        for (int k = 0; k < 4; k++) apply(1'b1, therm_of(1), 1'b0);
        wait_sum(12, got);
        n_vec++; if (!got || sum_out !== 5'd4) begin n_err++; $display("FAIL dec_next_window: got %0d want 4", sum_out); end
        apply(1'b1, therm_of(1), 1'b0);
        apply(1'b1, therm_of(2), 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, 7'd0, 1'b0);
        apply(1'b1, therm_of(3), 1'b0);
        apply(1'b1, therm_of(4), 1'b0);
        wait_sum(12, got);
        n_vec++; if (!got || sum_out !== 5'd10) begin n_err++; $display("FAIL dec_gap: got %0d want 10", sum_out); end
    endtask

    task automatic test_acc_clr();
        bit got;
        int pulses;
        do_reset();
        for (int k = 1; k <= 4; k++) apply(1'b1, therm_of(k), 1'b0);
        wait_sum(12, got);
        n_vec++; if (!got || sum_out !== 5'd10) begin n_err++; $display("FAIL clr_setup: got %0d want 10", sum_out); end
        for (int i = 0; i < 4; i++) apply(1'b1, therm_of(6), 1'b0);
        for (int i = 0; i < 3; i++) apply(1'b0, 7'd0, 1'b0);
        pulses = 0;
        apply(1'b0, 7'd0, 1'b1);
        if (sum_valid === 1'b1) pulses++;
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, 7'd0, 1'b0);
            if (sum_valid === 1'b1) pulses++;
        end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL clr_strobe: got %0d pulses want 0", pulses); end
        n_vec++; if (sum_out !== 5'd10) begin n_err++; $display("FAIL clr_hold: got %0d want 10", sum_out); end
        for (int i = 0; i < 4; i++) apply(1'b1, therm_of(6), 1'b0);
        wait_sum(12, got);
        n_vec++; if (!got || sum_out !== 5'd24) begin n_err++; $display("FAIL clr_after: got %0d want 24", sum_out); end
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset();
        for (int k = 1; k <= 4; k++) apply(1'b1, therm_of(k), 1'b0);
        wait_sum(12, got);
        apply(1'b1, therm_of(2), 1'b0);
        apply(1'b1, therm_of(2), 1'b0);
        apply(1'b1, 7'b1111111, 1'b0);
        apply(1'b1, 7'b1111111, 1'b0);
        apply(1'b1, 7'b1111111, 1'b0);
        rst = 1'b1;
        apply(1'b1, 7'b1111111, 1'b0);
        rst = 1'b0;
        n_vec++; if (onehot_out !== 8'h01) begin n_err++; $display("FAIL mid_onehot: got %h want 01", onehot_out); end
        n_vec++; if (code_out !== 3'd0 || code_valid !== 1'b0) begin n_err++; $display("FAIL mid_code: got %0d/%b want 0/0", code_out, code_valid); end
        n_vec++; if (sum_out !== 5'd0 || sum_valid !== 1'b0) begin n_err++; $display("FAIL mid_sum: got %0d/%b want 0/0", sum_out, sum_valid); end
        for (int i = 0; i < 4; i++) apply(1'b1, therm_of(3), 1'b0);
        wait_sum(12, got);
        n_vec++; if (!got || sum_out !== 5'd12) begin n_err++; $display("FAIL mid_after: got %0d want 12", sum_out); end
    endtask

    task automatic test_random();
        logic [6:0] t;
        logic       e;
        logic       c;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 4) == 0) t = 7'($urandom);
            else t = therm_of($urandom_range(0, 7));
            apply(e, t, c);
            n_vec++; if (onehot_out !== exp_onehot) begin n_err++; $display("FAIL rnd_onehot@%0d: got %b want %b", n, onehot_out, exp_onehot); end
            n_vec++; if (bubble_err !== exp_bubble) begin n_err++; $display("FAIL rnd_bubble@%0d: got %b want %b", n, bubble_err, exp_bubble); end
            n_vec++; if (code_out !== exp_code) begin n_err++; $display("FAIL rnd_code@%0d: got %0d want %0d", n, code_out, exp_code); end
            n_vec++; if (code_valid !== exp_cv) begin n_err++; $display("FAIL rnd_code_valid@%0d: got %b want %b", n, code_valid, exp_cv); end
            n_vec++; if (sum_valid !== exp_sv) begin n_err++; $display("FAIL rnd_sum_valid@%0d: got %b want %b", n, sum_valid, exp_sv); end
            n_vec++; if (sum_out !== exp_sum) begin n_err++; $display("FAIL rnd_sum@%0d: got %0d want %0d", n, sum_out, exp_sum); end
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        acc_clr  = 1'b0;
        therm_in = 7'd0;
        model_reset();
        test_reset();
        test_static();
        test_bubble();
        test_extremes();
        test_decimation();
        test_acc_clr();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
